// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: word RAM with loader port, fixed-latency one-outstanding fetch, misaligned/out-of-range flagging.
// Latency LATENCY cycles from request acceptance; rsp holds under rsp_ready=0 and req_ready stays low until the response is taken.
// Optional macro IMEM_FLUSH_EN adds a flush input that drops the outstanding fetch.
module imem_fetch_responder #(
    parameter int                    INST_MAX     = 32,
    parameter int                    WIDTH        = 32,
    parameter logic [WIDTH-1:0]      PC_START     = 32'h8000_0000,
    parameter int                    DEPTH        = 1024,
    parameter int                    LATENCY      = 2,
    parameter logic [INST_MAX-1:0]   ILLEGAL_INST = 32'h0010_0073
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [WIDTH-1:0]         req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [INST_MAX-1:0]      rsp_inst,
    output logic                     rsp_err,
`ifdef IMEM_FLUSH_EN
    input  logic                     flush,
`endif
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [INST_MAX-1:0]      load_data
);

    localparam int               AW          = $clog2(DEPTH);
    localparam logic [WIDTH:0]   RANGE_BYTES = (WIDTH+1)'(DEPTH * 4);
    localparam logic [3:0]       LAT_M1      = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [WIDTH-1:0]      addr_q, addr_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [INST_MAX-1:0]   rsp_inst_q, rsp_inst_d;

    logic [INST_MAX-1:0]   mem [DEPTH];

    logic                  flush_w;
    logic [WIDTH-1:0]      fetch_addr;
    logic [WIDTH-1:0]      offset;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  fetch_err;
    logic [AW-1:0]         rd_idx;
    logic [INST_MAX-1:0]   rd_word;
    logic                  load_rsp;

`ifdef IMEM_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // With LATENCY=1 the RAM is read on the acceptance edge, so the live request address is used.
    assign fetch_addr   = (state_q == IDLE) ? req_addr : addr_q;
    assign offset       = fetch_addr - PC_START;
    assign misaligned   = (fetch_addr[1:0] != 2'b00);
    assign out_of_range = ({1'b0, offset} >= RANGE_BYTES);
    assign fetch_err    = misaligned | out_of_range;
    assign rd_idx       = offset[AW+1:2];
    assign rd_word      = mem[rd_idx];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_inst_d  = rsp_inst_q;
        load_rsp    = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    addr_d      = req_addr;
                    cnt_d       = LAT_M1;
                    req_ready_d = 1'b0;
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                    end else begin
                        state_d  = RESP;
                        load_rsp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (flush_w) begin
                    state_d     = IDLE;
                    cnt_d       = 4'd0;
                    req_ready_d = 1'b1;
                end else if (cnt_q <= 4'd1) begin
                    state_d  = RESP;
                    cnt_d    = 4'd0;
                    load_rsp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // flush outranks rsp_ready; both retire the fetch, only flush discards it unseen.
                if (flush_w || rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b0;
            end
        endcase

        if (load_rsp) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = fetch_err;
            rsp_inst_d  = fetch_err ? ILLEGAL_INST : rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_inst_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_inst_q  <= rsp_inst_d;
        end
    end

    // Loader writes ignore reset; a same-edge read sees the previous contents.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_inst  = rsp_inst_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench for imem_fetch_responder: scoreboard of expected responses, default parameters (LATENCY=2, DEPTH=1024).
module tb_imem_fetch_responder;

    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_inst;
    logic        rsp_err;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;
`ifdef IMEM_FLUSH_EN
    logic        flush;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_inst_q [$];
    logic        exp_err_q  [$];

    imem_fetch_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_inst  (rsp_inst),
        .rsp_err   (rsp_err),
`ifdef IMEM_FLUSH_EN
        .flush     (flush),
`endif
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_word(input logic [9:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_wait", {31'b0, req_ready}, 32'd1);
    endtask

    // Accepts one fetch, checks when rsp_valid appears, optionally stalls the response,
    // optionally fires a loader write on the edge that enters RESP, then retires the response.
    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] e_inst,
                         input logic e_err, input int hold, input bit coll);
        int          lat;
        logic [31:0] got_inst;
        logic        got_err;
        logic [31:0] want_inst;
        logic        want_err;
        wait_ready();
        req_valid = 1'b1;
        req_addr  = addr;
        exp_inst_q.push_back(e_inst);
        exp_err_q.push_back(e_err);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'h0;
        if (coll) begin
            load_en   = 1'b1;
            load_addr = 10'd1;
            load_data = 32'hDEAD_BEEF;
        end
        // Visible after edge T+LATENCY-1, so the core samples it high at edge T+LATENCY.
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            load_en = 1'b0;
            lat++;
        end
        load_en = 1'b0;
        check({tag, "_latency"}, lat, LATENCY - 1);
        got_inst = rsp_inst;
        got_err  = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_vld"}, {31'b0, rsp_valid}, 32'd1);
            check({tag, "_hold_inst"}, rsp_inst, got_inst);
            check({tag, "_hold_err"}, {31'b0, rsp_err}, {31'b0, got_err});
            check({tag, "_hold_rdy"}, {31'b0, req_ready}, 32'd0);
        end
        if (exp_inst_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            want_inst = exp_inst_q.pop_front();
            want_err  = exp_err_q.pop_front();
            check({tag, "_inst"}, rsp_inst, want_inst);
            check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, want_err});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_vld_drop"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, "_rdy_back"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check(tag, seen, 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        rsp_ready = 1'b0;
        load_en   = 1'b0;
        load_addr = 10'd0;
        load_data = 32'h0;
`ifdef IMEM_FLUSH_EN
        flush     = 1'b0;
`endif
        @(negedge clk);
        // Loader works while reset is held.
        load_word(10'd0, 32'h0000_0513);
        load_word(10'd1, 32'h0010_0093);
        load_word(10'd1023, 32'h1234_5678);
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_inst", rsp_inst, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'b0, req_ready}, 32'd1);

        fetch("f0", 32'h8000_0000, 32'h0000_0513, 1'b0, 0, 1'b0);
        fetch("f4", 32'h8000_0004, 32'h0010_0093, 1'b0, 5, 1'b0);
        fetch("misal", 32'h8000_0002, 32'h0010_0073, 1'b1, 0, 1'b0);
        fetch("oor_hi", 32'h8000_1000, 32'h0010_0073, 1'b1, 0, 1'b0);
        fetch("oor_lo", 32'h7FFF_FFFC, 32'h0010_0073, 1'b1, 0, 1'b0);
        fetch("last", 32'h8000_0FFC, 32'h1234_5678, 1'b0, 0, 1'b0);
        fetch("coll", 32'h8000_0004, 32'h0010_0093, 1'b0, 0, 1'b1);
        fetch("refetch", 32'h8000_0004, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);

        // Reset during WAIT: the fetch is abandoned and never answered.
        wait_ready();
        req_valid = 1'b1;
        req_addr  = 32'h8000_0004;
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        check("midrst_vld", {31'b0, rsp_valid}, 32'd0);
        check("midrst_inst", rsp_inst, 32'd0);
        check("midrst_rdy", {31'b0, req_ready}, 32'd0);
        rst = 1'b1;
        expect_quiet("midrst_no_stale", 4);
        fetch("after_rst", 32'h8000_0000, 32'h0000_0513, 1'b0, 0, 1'b0);

`ifdef IMEM_FLUSH_EN
        wait_ready();
        req_valid = 1'b1;
        req_addr  = 32'h8000_0004;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_vld", {31'b0, rsp_valid}, 32'd0);
        check("flush_rdy", {31'b0, req_ready}, 32'd1);
        expect_quiet("flush_no_rsp", 4);
        fetch("after_flush", 32'h8000_0000, 32'h0000_0513, 1'b0, 0, 1'b0);
`endif

        check("sb_drained", exp_inst_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Instruction-memory responder serving the fetch side of the single-cycle core. The core (initiator) presents a PC, and this block returns the 32-bit instruction word after a fixed, programmable latency.
- Holds a word-addressed program RAM preloaded through a loader write port.
- Flags misaligned and out-of-range fetches so the core can trap instead of executing garbage.
- Sits between the core's pc output and its inst input once the core gains a stall-capable fetch stage.

Parameters:
- INST_MAX, 32, instruction word width.
- WIDTH, 32, address width.
- PC_START, 32'h8000_0000, byte address of RAM word 0.
- DEPTH, 1024, RAM depth in words (power of two).
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.
- ILLEGAL_INST, 32'h0010_0073, word returned on error (ebreak).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  WIDTH  fetch byte address (PC).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  core accepts the response.
- rsp_inst  out  INST_MAX  fetched instruction.
- rsp_err  out  1  1 = misaligned or out-of-range fetch.
- load_en  in  1  loader write strobe.
- load_addr  in  $clog2(DEPTH)  loader word index.
- load_data  in  INST_MAX  loader write data.
- flush  in  1  present only with IMEM_FLUSH_EN; drop the outstanding fetch.

Behaviour:
- Reset: rst sampled low at a rising edge puts the FSM in IDLE. Reset values: req_ready=0 during the reset cycle and 1 from the first cycle after rst goes high; rsp_valid=0; rsp_inst=0; rsp_err=0; latency counter=0.
- Reset does not clear RAM contents.
- Reset asserted mid-operation abandons any outstanding fetch; no response is ever issued for it.
- FSM states:
  - IDLE: req_ready=1. On req_valid at the edge, capture req_addr and load counter=LATENCY-1. Go to WAIT if LATENCY>1, else RESP.
  - WAIT: req_ready=0. Decrement the counter each cycle. When the counter reaches 1 and the edge occurs, go to RESP.
  - RESP: rsp_valid=1. rsp_inst and rsp_err are held stable while rsp_valid=1 and rsp_ready=0. On rsp_ready at the edge, go to IDLE.
- req_ready is 0 in WAIT and RESP. Only one fetch is outstanding at a time; throughput is one fetch per LATENCY+1 cycles minimum.
- Timing: request accepted at edge T gives rsp_valid high from edge T+LATENCY.
- Address checks on the captured address; offset = addr - PC_START, computed modulo 2^WIDTH.
  - Misaligned: addr[1:0]!=0 gives rsp_err=1 and rsp_inst=ILLEGAL_INST.
  - Out of range: offset >= DEPTH*4 gives rsp_err=1 and rsp_inst=ILLEGAL_INST. Addresses below PC_START wrap to a huge offset and are therefore out of range.
  - Otherwise: rsp_inst = RAM[offset>>2] and rsp_err=0.
- RAM read timing: RAM is read on the edge entering RESP and registered into rsp_inst.
- Loader writes: load_en writes RAM[load_addr]=load_data at the edge, in any state and regardless of rst.
- Load/fetch collision: a load to the same word on the edge entering RESP returns the old data (read-before-write). A load during WAIT to the fetched word is visible in the response.
- rsp_ready asserted while rsp_valid=0 is ignored.

Optional Feature:
- Macro: IMEM_FLUSH_EN.
- With IMEM_FLUSH_EN defined:
  - flush is sampled at the edge in WAIT or RESP: the FSM returns to IDLE, rsp_valid drops next cycle, and no response is issued for the dropped fetch.
  - flush in IDLE is ignored; a simultaneous req_valid is still accepted.
  - flush has priority over rsp_ready.
- Without the macro: no flush port; the FSM follows the rules above only.

Test Plan:
- Load RAM[0]=32'h0000_0513 and RAM[1]=32'h0010_0093. With LATENCY=2, fetch 32'h8000_0000 then 32'h8000_0004 -> responses 32'h0000_0513 then 32'h0010_0093, rsp_err=0, rsp_valid exactly 2 cycles after each acceptance.
- Fetch 32'h8000_0002 -> rsp_err=1, rsp_inst=32'h0010_0073. Fetch 32'h8000_1000 (DEPTH=1024) -> rsp_err=1. Fetch 32'h7FFF_FFFC -> rsp_err=1.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_inst and rsp_err stay constant and req_ready stays 0. Raise rsp_ready -> req_ready=1 the next cycle.
- Drive rst low during WAIT -> next cycle rsp_valid=0 and rsp_inst=0. After rst goes high, a fresh fetch of 32'h8000_0000 returns RAM[0] with correct latency and no stale response.
- Load collision: load_en to RAM[1]=32'hDEAD_BEEF on the edge entering RESP for fetch 32'h8000_0004 -> old word returned. A refetch returns 32'hDEAD_BEEF.
- IMEM_FLUSH_EN: assert flush in WAIT -> no rsp_valid for that fetch and req_ready=1 the next cycle. A subsequent fetch returns correct data.
